// File: rtl/axis_fp_result_tx.sv
// rtl/axis_fp_result_tx.sv - AXI4-Stream result transmitter: circular FIFO plus fixed-length packetiser
module axis_fp_result_tx #(
    parameter int data    = 32,
    parameter int DEPTH   = 4,
    parameter int PKT_LEN = 8
) (
    input  logic                     axis_clk,
    input  logic                     axis_reset,
    input  logic                     s_res_valid,
    output logic                     s_res_ready,
    input  logic [data-1:0]          s_res_data,
    output logic                     m_axis_valid,
    input  logic                     m_axis_ready,
    output logic [data-1:0]          m_axis_data,
    output logic                     m_axis_last,
    output logic [data/8-1:0]        m_axis_keep,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

    logic [data-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [BW-1:0]   beat_cnt;
    logic            push;
    logic            pop;

    // Ready depends on registered occupancy only, so a full FIFO never passes through.
    assign s_res_ready  = (count != CW'(DEPTH));
    assign m_axis_valid = (count != '0);
    assign push         = s_res_valid & s_res_ready;
    assign pop          = m_axis_valid & m_axis_ready;

    assign m_axis_data  = mem[rd_ptr];
    assign m_axis_last  = m_axis_valid & (beat_cnt == LAST_BEAT);
    assign m_axis_keep  = '1;
    assign fifo_count   = count;

    always_ff @(posedge axis_clk) begin
        if (axis_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_cnt <= '0;
            // Clearing storage keeps m_axis_data deterministic (zero) straight after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_res_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            // Packet boundaries follow accepted beats only; an empty FIFO leaves the packet open.
            if (pop) begin
                if (beat_cnt == LAST_BEAT) begin
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + BW'(1);
                end
            end
        end
    end

endmodule
